multdiv_step_counter: RTL and testbench

Parametrised iteration counter for the multiplier/divider control path, replacing the fixed 6-bit free-running toggle counter. It runs a programmable number of steps per operation. A start/busy/done handshake, stall and abort inputs, and a selectable up or down count direction make it the single step sequencer shared by the multdiv datapaths.

---
 rtl/multdiv_step_counter.sv | 100 ++++++++++
 tb/tb_multdiv_step_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_step_counter.sv
// ============================================================================
// multdiv_step_counter : programmable step sequencer for the multdiv datapaths
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_step_counter #(
  parameter int WIDTH      = 6,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             stall,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_limit, w_limit_nxt;
  logic [WIDTH-1:0] w_end;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  // limit_q == 0 wraps to all-ones, giving the 2^WIDTH-step case for free
  assign w_end    = COUNT_DOWN ? C_ZERO : (r_limit - C_ONE);
  assign w_first  = COUNT_DOWN ? (limit - C_ONE) : C_ZERO;
  assign w_step   = COUNT_DOWN ? (r_count - C_ONE) : (r_count + C_ONE);
  assign w_accept = start && !abort;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_count <= C_ZERO;
      r_limit <= C_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    case (r_state)
      S_IDLE, S_DONE: begin
        // DONE lasts one cycle; a start there restarts with no idle gap
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_count_nxt = w_first;
          w_limit_nxt = limit;
        end else begin
          w_state_nxt = S_IDLE;
          w_count_nxt = C_ZERO;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = C_ZERO;
        end else if (stall) begin
          w_state_nxt = S_RUN;
        end else if (r_count == w_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = w_step;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = C_ZERO;
      end
    endcase
  end

  assign count = r_count;
  assign busy  = (r_state == S_RUN);
  assign last  = (r_state == S_RUN) && (r_count == w_end);
  assign done  = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_step_counter.sv
// ============================================================================
// tb_multdiv_step_counter : directed bench for up- and down-counting instances
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_step_counter;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             stall;
  logic             abort;

  logic [WIDTH-1:0] count_u, count_d;
  logic             busy_u, last_u, done_u;
  logic             busy_d, last_d, done_d;

  int vectors     = 0;
  int miscompares = 0;

  multdiv_step_counter #(.WIDTH(WIDTH), .COUNT_DOWN(1'b0)) u_up (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .limit (limit),
    .stall (stall),
    .abort (abort),
    .count (count_u),
    .busy  (busy_u),
    .last  (last_u),
    .done  (done_u)
  );

  multdiv_step_counter #(.WIDTH(WIDTH), .COUNT_DOWN(1'b1)) u_dn (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .limit (limit),
    .stall (stall),
    .abort (abort),
    .count (count_d),
    .busy  (busy_d),
    .last  (last_d),
    .done  (done_d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {count, busy, last, done} of the selected instance
  task automatic chk(input string tag, input bit dn, input logic [WIDTH-1:0] e_cnt,
                     input logic e_busy, input logic e_last, input logic e_done);
    logic [WIDTH+2:0] obs;
    logic [WIDTH+2:0] exp;
    obs = dn ? {count_d, busy_d, last_d, done_d} : {count_u, busy_u, last_u, done_u};
    exp = {e_cnt, e_busy, e_last, e_done};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed cnt=%0d b/l/d=%b required cnt=%0d b/l/d=%b",
             tag, obs[WIDTH+2:3], obs[2:0], exp[WIDTH+2:3], exp[2:0]);
    end
  endtask

  initial begin : stim
    logic [WIDTH-1:0] st_cnt [6];
    logic             st_stl [6];
    logic             st_lst [6];

    clr_n = 1'b0;
    start = 1'b0;
    limit = '0;
    stall = 1'b0;
    abort = 1'b0;

    tick();
    tick();
    chk("reset_up", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_dn", 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    clr_n = 1'b1;
    tick();
    chk("post_reset_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Plain up count, L=5
    limit = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("up5_run", 1'b0, 6'(i), 1'b1, (i == 4), 1'b0);
      tick();
    end
    chk("up5_done", 1'b0, 6'd4, 1'b0, 1'b0, 1'b1);
    tick();
    chk("up5_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Stalls, L=4: expect 0,1,1,2,3,3
    st_cnt = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd3};
    st_stl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    st_lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    limit = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stall_run", 1'b0, st_cnt[i], 1'b1, st_lst[i], 1'b0);
      stall = st_stl[i];
      tick();
    end
    stall = 1'b0;
    chk("stall_done", 1'b0, 6'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // limit=0 means 64 steps
    limit = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("lim0_run", 1'b0, 6'(i), 1'b1, (i == 63), 1'b0);
      tick();
    end
    chk("lim0_done", 1'b0, 6'd63, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lim0_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // limit=1: last immediately
    limit = 6'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lim1_run", 1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lim1_done", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lim1_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Down count L=3, then back-to-back restart with L=2 during done
    limit = 6'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn3_run0", 1'b1, 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("dn3_run1", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("dn3_run2", 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("dn3_done", 1'b1, 6'd0, 1'b0, 1'b0, 1'b1);
    limit = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_run0", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_run1", 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b2b_done", 1'b1, 6'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("b2b_idle", 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Abort at count=2 of L=10 with start also high
    limit = 6'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_pre", 1'b0, 6'd2, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    limit = 6'd7;
    tick();
    chk("abort_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort_idle_start", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    tick();
    chk("abort_no_done", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Start mid-RUN with a different limit must not disturb L=3
    limit = 6'd3;
    start = 1'b1;
    tick();
    limit = 6'd7;
    chk("ign_run0", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ign_run1", 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    chk("ign_run2", 1'b0, 6'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ign_done", 1'b0, 6'd2, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ign_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges at count=3
    limit = 6'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre", 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
    #2;
    clr_n = 1'b0;
    #1;
    chk("rst_async_up", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_async_dn", 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    limit = 6'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_clean_run0", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_clean_run1", 1'b0, 6'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rst_clean_done", 1'b0, 6'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_clean_idle", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
